// File: rtl/video_line_scheduler.sv
// Double-buffered line render sequencer: one render request per output line into the
// hidden line-buffer half, scaled read addressing for the displayed half, underrun flagging.
module video_line_scheduler #(
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_frame,
    input  logic        next_line,
    input  logic        next_pixel,
    input  logic        current_field,
    input  logic        interlace,
    input  logic [7:0]  hscale,
    input  logic [7:0]  vscale,
    input  logic [8:0]  irq_line,
    output logic        render_start,
    output logic [8:0]  render_line,
    output logic        render_buf,
    input  logic        render_done,
    output logic        lb_rd_buf,
    output logic [9:0]  lb_rd_addr,
    output logic        underrun,
    output logic        line_irq
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RENDER = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [9:0] ADDR_MAX  = 10'(LINE_WIDTH - 1);
    localparam logic [9:0] LINES_LIM = 10'(NUM_LINES);

    logic [1:0]  state;
    logic [15:0] v_acc;
    logic [16:0] h_acc;

    logic        issue;
    logic [15:0] v_step;
    logic [15:0] v_next;
    logic [8:0]  next_line_num;
    logic        line_valid;
    logic [17:0] h_sum;
    logic [16:0] h_next;
    logic [9:0]  addr_raw;
    logic [9:0]  addr_clamped;

    always_comb begin
        issue  = next_line && ((state != S_IDLE) || next_frame);
        v_step = interlace ? {7'd0, vscale, 1'b0} : {8'd0, vscale};
        if (next_frame) begin
            v_next = (interlace && current_field) ? {8'd0, vscale} : '0;
        end else begin
            v_next = v_acc + v_step;
        end
        next_line_num = v_next[15:7];
        line_valid    = {1'b0, next_line_num} < LINES_LIM;

        // Accumulator pins at all-ones so the clamped address can never wrap back to 0.
        h_sum  = {1'b0, h_acc} + {10'd0, hscale};
        h_next = h_sum[17] ? '1 : h_sum[16:0];

        addr_raw     = h_acc[16:7];
        addr_clamped = (addr_raw > ADDR_MAX) ? ADDR_MAX : addr_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            v_acc        <= '0;
            h_acc        <= '0;
            render_start <= 1'b0;
            render_line  <= '0;
            render_buf   <= 1'b0;
            lb_rd_buf    <= 1'b0;
            lb_rd_addr   <= '0;
            underrun     <= 1'b0;
            line_irq     <= 1'b0;
        end else begin
            render_start <= 1'b0;
            underrun     <= 1'b0;
            line_irq     <= 1'b0;

            if (next_line) begin
                h_acc <= '0;
            end else if (next_pixel) begin
                h_acc <= h_next;
            end
            lb_rd_addr <= addr_clamped;

            if (issue) begin
                underrun <= (state == S_RENDER) && !render_done;
                if (state != S_IDLE) begin
                    lb_rd_buf  <= ~lb_rd_buf;
                    render_buf <= lb_rd_buf;
                end else begin
                    render_buf <= ~lb_rd_buf;
                end
                v_acc <= v_next;
                if (line_valid) begin
                    render_line  <= next_line_num;
                    render_start <= 1'b1;
                    line_irq     <= (next_line_num == irq_line);
                    state        <= S_RENDER;
                end else begin
                    state <= S_DONE;
                end
            end else if ((state == S_RENDER) && render_done) begin
                state <= S_DONE;
            end
        end
    end

endmodule
